// File: rtl/xburst_mem_pkg.sv
// xburst_mem_pkg: shared burst responder parameters, FSM encodings and helpers.
package xburst_mem_pkg;
    localparam int ADDR_W_D     = 32;
    localparam int DATA_W_D     = 32;
    localparam int LEN_W_D      = 8;
    localparam int MEM_ADDR_W_D = 10;

    localparam logic [0:0] W_IDLE   = 1'b0;
    localparam logic [0:0] W_BURST  = 1'b1;
    localparam logic [0:0] R_IDLE   = 1'b0;
    localparam logic [0:0] R_ACTIVE = 1'b1;

    // Bytes per beat as a shift; beats per burst are always len+1.
    function automatic int byte_off_w(input int data_w);
        return $clog2(data_w / 8);
    endfunction
endpackage

// File: rtl/xburst_mem_if.sv
// xburst_mem_if: split write/read burst channels plus the dual-port memory side.
interface xburst_mem_if import xburst_mem_pkg::*; #(
    parameter int ADDR_W     = ADDR_W_D,
    parameter int DATA_W     = DATA_W_D,
    parameter int LEN_W      = LEN_W_D,
    parameter int MEM_ADDR_W = MEM_ADDR_W_D
);
    logic                  s_wvalid_i;
    logic                  s_wready_o;
    logic [ADDR_W-1:0]     s_waddr_i;
    logic [DATA_W-1:0]     s_wdata_i;
    logic [DATA_W/8-1:0]   s_wstrb_i;
    logic [LEN_W-1:0]      s_wlen_i;
    logic                  s_wlast_o;
    logic                  s_rvalid_i;
    logic                  s_rready_o;
    logic [ADDR_W-1:0]     s_raddr_i;
    logic [DATA_W-1:0]     s_rdata_o;
    logic [LEN_W-1:0]      s_rlen_i;
    logic                  s_rlast_o;
    logic                  mem_wen_o;
    logic [MEM_ADDR_W-1:0] mem_waddr_o;
    logic [DATA_W-1:0]     mem_wdata_o;
    logic [DATA_W/8-1:0]   mem_wstrb_o;
    logic                  mem_ren_o;
    logic [MEM_ADDR_W-1:0] mem_raddr_o;
    logic [DATA_W-1:0]     mem_rdata_i;

    modport slave (
        input  s_wvalid_i, s_waddr_i, s_wdata_i, s_wstrb_i, s_wlen_i,
        input  s_rvalid_i, s_raddr_i, s_rlen_i, mem_rdata_i,
        output s_wready_o, s_wlast_o, s_rready_o, s_rdata_o, s_rlast_o,
        output mem_wen_o, mem_waddr_o, mem_wdata_o, mem_wstrb_o, mem_ren_o, mem_raddr_o
    );

    modport master (
        output s_wvalid_i, s_waddr_i, s_wdata_i, s_wstrb_i, s_wlen_i,
        output s_rvalid_i, s_raddr_i, s_rlen_i, mem_rdata_i,
        input  s_wready_o, s_wlast_o, s_rready_o, s_rdata_o, s_rlast_o,
        input  mem_wen_o, mem_waddr_o, mem_wdata_o, mem_wstrb_o, mem_ren_o, mem_raddr_o
    );
endinterface

// File: rtl/xburst_mem_xfifo2.sv
// xburst_mem_xfifo2: 2-entry register FIFO, head always visible, pop and push may coincide.
module xburst_mem_xfifo2 #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_head,
    output logic [1:0]   o_count
);
    logic [W-1:0] r_d0, r_d1;
    logic [1:0]   r_cnt;

    assign o_head  = r_d0;
    assign o_count = r_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_d0  <= '0;
            r_d1  <= '0;
            r_cnt <= '0;
        end else begin
            if (i_pop) begin
                r_d0 <= (i_push && r_cnt == 2'd1) ? i_data : r_d1;
                if (i_push && r_cnt == 2'd2) r_d1 <= i_data;
            end else if (i_push) begin
                if (r_cnt == 2'd0) r_d0 <= i_data;
                else r_d1 <= i_data;
            end
            r_cnt <= r_cnt + {1'b0, i_push} - {1'b0, i_pop};
        end
    end
endmodule

// File: rtl/xburst_mem.sv
// xburst_mem: burst responder terminating split write/read channels onto a 1R1W word memory.
module xburst_mem import xburst_mem_pkg::*; #(
    parameter int ADDR_W     = ADDR_W_D,
    parameter int DATA_W     = DATA_W_D,
    parameter int LEN_W      = LEN_W_D,
    parameter int MEM_ADDR_W = MEM_ADDR_W_D
) (
    input logic         clk_i,
    input logic         rst_i,
    xburst_mem_if.slave bus
);
    localparam int BOW = byte_off_w(DATA_W);

    logic                  r_wready;
    logic [0:0]            r_wstate;
    logic [LEN_W-1:0]      r_wrem;
    logic [MEM_ADDR_W-1:0] r_waddr;
    logic                  w_wburst, w_wfire;
    logic [MEM_ADDR_W-1:0] w_waddr;

    assign w_wburst = r_wstate == W_BURST;
    assign w_waddr  = w_wburst ? r_waddr : bus.s_waddr_i[BOW +: MEM_ADDR_W];
    assign w_wfire  = bus.s_wvalid_i & r_wready;

    // The memory side is zero-latency; gating with r_wready keeps it quiet while in reset.
    assign bus.s_wready_o  = r_wready;
    assign bus.s_wlast_o   = r_wready & (w_wburst ? r_wrem == '0 : bus.s_wlen_i == '0);
    assign bus.mem_wen_o   = w_wfire;
    assign bus.mem_waddr_o = r_wready ? w_waddr : '0;
    assign bus.mem_wdata_o = r_wready ? bus.s_wdata_i : '0;
    assign bus.mem_wstrb_o = r_wready ? bus.s_wstrb_i : '0;

    // r_wrem counts beats still owed after the current one.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wready <= 1'b0;
            r_wstate <= W_IDLE;
            r_wrem   <= '0;
            r_waddr  <= '0;
        end else begin
            r_wready <= 1'b1;
            if (w_wfire) begin
                r_waddr  <= w_waddr + 1'b1;
                r_wrem   <= (w_wburst ? r_wrem : bus.s_wlen_i) - 1'b1;
                r_wstate <= (w_wburst ? r_wrem != '0 : bus.s_wlen_i != '0) ? W_BURST : W_IDLE;
            end
        end
    end

    logic [0:0]            r_rstate;
    logic [MEM_ADDR_W-1:0] r_raddr;
    logic [LEN_W-1:0]      r_rlen, r_sent;
    logic [LEN_W:0]        r_issue;
    logic                  r_inflight;
    logic [1:0]            w_count;
    logic                  w_nempty, w_pop, w_ren;

    assign w_nempty = w_count != 2'd0;
    assign w_pop    = bus.s_rvalid_i & w_nempty;
    // Credit: buffered + in-flight beats never exceed the two FIFO slots.
    assign w_ren    = r_rstate == R_ACTIVE && r_issue <= {1'b0, r_rlen} &&
                      {1'b0, w_count} + {2'b0, r_inflight} < 3'd2 + {2'b0, w_pop};

    assign bus.s_rready_o  = w_nempty;
    assign bus.s_rlast_o   = w_nempty & (r_sent == r_rlen);
    assign bus.mem_ren_o   = w_ren;
    assign bus.mem_raddr_o = r_raddr;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rstate   <= R_IDLE;
            r_raddr    <= '0;
            r_rlen     <= '0;
            r_sent     <= '0;
            r_issue    <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_ren;
            if (r_rstate == R_IDLE) begin
                if (bus.s_rvalid_i) begin
                    r_rstate <= R_ACTIVE;
                    r_raddr  <= bus.s_raddr_i[BOW +: MEM_ADDR_W];
                    r_rlen   <= bus.s_rlen_i;
                    r_issue  <= '0;
                    r_sent   <= '0;
                end
            end else begin
                if (w_ren) begin
                    r_raddr <= r_raddr + 1'b1;
                    r_issue <= r_issue + 1'b1;
                end
                if (w_pop) begin
                    r_sent <= r_sent + 1'b1;
                    if (bus.s_rlast_o) r_rstate <= R_IDLE;
                end
            end
        end
    end

    xburst_mem_xfifo2 #(.W(DATA_W)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_push  (r_inflight),
        .i_pop   (w_pop),
        .i_data  (bus.mem_rdata_i),
        .o_head  (bus.s_rdata_o),
        .o_count (w_count)
    );
endmodule

// File: tb/tb_xburst_mem.sv
// tb_xburst_mem: directed checks of xburst_mem write/read bursts against a behavioural memory.
module tb_xburst_mem;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic preload = 1'b1;
    int total = 0;
    int bad = 0;
    logic [31:0] mem [1024];

    xburst_mem_if bus ();

    xburst_mem dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Memory model: zero-latency write, one-cycle read latency.
    always @(posedge clk) begin
        if (preload) begin
            for (int k = 0; k < 1024; k++) mem[k] <= k;
        end else begin
            if (bus.mem_wen_o)
                for (int b = 0; b < 4; b++)
                    if (bus.mem_wstrb_o[b]) mem[bus.mem_waddr_o][8*b +: 8] <= bus.mem_wdata_o[8*b +: 8];
            if (bus.mem_ren_o) bus.mem_rdata_i <= mem[bus.mem_raddr_o];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rd_held(input logic [31:0] a, input logic [7:0] len, input string tag);
        int w;
        w = (a >> 2) % 1024;
        @(negedge clk);
        bus.s_raddr_i = a;
        bus.s_rlen_i = len;
        bus.s_rvalid_i = 1'b1;
        #1 chk({tag, "_rready_c0"}, bus.s_rready_o, 0);
        @(negedge clk);
        bus.s_raddr_i = 32'h0000_0ff0;
        bus.s_rlen_i = 8'd0;
        #1 chk({tag, "_ren_c1"}, bus.mem_ren_o, 1);
        chk({tag, "_raddr_c1"}, bus.mem_raddr_o, w);
        @(negedge clk);
        #1 chk({tag, "_rready_c2"}, bus.s_rready_o, 0);
        for (int k = 0; k <= int'(len); k++) begin
            @(negedge clk);
            #1 chk({tag, "_rready"}, bus.s_rready_o, 1);
            chk({tag, "_rdata"}, bus.s_rdata_o, mem[(w + k) % 1024]);
            chk({tag, "_rlast"}, bus.s_rlast_o, k == int'(len));
        end
        @(negedge clk);
        bus.s_rvalid_i = 1'b0;
        #1 chk({tag, "_rready_end"}, bus.s_rready_o, 0);
    endtask

    initial begin
        int got, iss, p;
        logic stalled;
        bus.s_wvalid_i = 1'b1;
        bus.s_waddr_i = 32'h40;
        bus.s_wdata_i = 32'hdead_beef;
        bus.s_wstrb_i = 4'hf;
        bus.s_wlen_i = 8'd0;
        bus.s_rvalid_i = 1'b1;
        bus.s_raddr_i = 32'h0;
        bus.s_rlen_i = 8'd0;
        repeat (2) @(negedge clk);
        #1 chk("rst_wready", bus.s_wready_o, 0);
        chk("rst_wlast", bus.s_wlast_o, 0);
        chk("rst_rready", bus.s_rready_o, 0);
        chk("rst_rlast", bus.s_rlast_o, 0);
        chk("rst_rdata", bus.s_rdata_o, 0);
        chk("rst_wen", bus.mem_wen_o, 0);
        chk("rst_waddr", bus.mem_waddr_o, 0);
        chk("rst_wdata", bus.mem_wdata_o, 0);
        chk("rst_wstrb", bus.mem_wstrb_o, 0);
        chk("rst_ren", bus.mem_ren_o, 0);
        chk("rst_raddr", bus.mem_raddr_o, 0);
        @(negedge clk);
        rst = 1'b0;
        preload = 1'b0;
        bus.s_wvalid_i = 1'b0;
        bus.s_rvalid_i = 1'b0;
        #1 chk("rel_wready_c0", bus.s_wready_o, 0);
        @(negedge clk);
        #1 chk("rel_wready_c1", bus.s_wready_o, 1);
        chk("rel_rready", bus.s_rready_o, 0);
        chk("rel_rlast", bus.s_rlast_o, 0);
        chk("rel_wen", bus.mem_wen_o, 0);

        rd_held(32'h0, 8'd7, "rd8");

        got = 0;
        iss = 0;
        stalled = 1'b0;
        for (int c = 0; c < 40 && got < 4; c++) begin
            @(negedge clk);
            bus.s_raddr_i = 32'h20;
            bus.s_rlen_i = 8'd3;
            bus.s_rvalid_i = (c % 2 == 0);
            #1 p = int'(bus.s_rvalid_i && bus.s_rready_o);
            chk("tog_outstanding", (iss + int'(bus.mem_ren_o) - got - p) <= 2, 1);
            if (c > 0 && !bus.mem_ren_o && iss < 4) stalled = 1'b1;
            iss += int'(bus.mem_ren_o);
            if (p != 0) begin
                chk("tog_rdata", bus.s_rdata_o, 8 + got);
                chk("tog_rlast", bus.s_rlast_o, got == 3);
                got++;
            end
        end
        chk("tog_beats", got, 4);
        chk("tog_issued", iss, 4);
        chk("tog_stall", stalled, 1);
        @(negedge clk);
        bus.s_rvalid_i = 1'b0;
        #1 chk("tog_rready_end", bus.s_rready_o, 0);

        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            bus.s_wvalid_i = (k != 2);
            bus.s_waddr_i = (k == 0) ? 32'h10 : 32'h300;
            bus.s_wlen_i = (k == 0) ? 8'd3 : 8'd0;
            bus.s_wdata_i = 32'ha0 + k;
            bus.s_wstrb_i = 4'hf;
            #1 chk("w4_wen", bus.mem_wen_o, k != 2);
            if (k != 2) begin
                chk("w4_waddr", bus.mem_waddr_o, 4 + k - (k > 2));
                chk("w4_wdata", bus.mem_wdata_o, 32'ha0 + k);
                chk("w4_wlast", bus.s_wlast_o, k == 4);
            end
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus.s_wvalid_i = 1'b1;
            bus.s_waddr_i = 32'h80 + 4 * k;
            bus.s_wlen_i = (k == 2) ? 8'd1 : 8'd0;
            bus.s_wdata_i = 32'h1100_0000 + k;
            bus.s_wstrb_i = (k == 3) ? 4'h3 : 4'hf;
            #1 chk("w1_waddr", bus.mem_waddr_o, 32 + k);
            chk("w1_wlast", bus.s_wlast_o, k != 2);
            chk("w1_wen", bus.mem_wen_o, 1);
        end
        @(negedge clk);
        bus.s_wvalid_i = 1'b0;
        #1 chk("mem4", mem[4], 32'ha0);
        chk("mem7", mem[7], 32'ha4);
        chk("mem32", mem[32], 32'h1100_0000);
        chk("mem35_strb", mem[35], 32'h0000_0003);

        @(negedge clk);
        bus.s_wvalid_i = 1'b1;
        bus.s_waddr_i = 32'hffc;
        bus.s_wlen_i = 8'd1;
        bus.s_wdata_i = 32'h55;
        #1 chk("wrap_waddr0", bus.mem_waddr_o, 1023);
        chk("wrap_wlast0", bus.s_wlast_o, 0);
        @(negedge clk);
        bus.s_wdata_i = 32'h66;
        #1 chk("wrap_waddr1", bus.mem_waddr_o, 0);
        chk("wrap_wlast1", bus.s_wlast_o, 1);
        @(negedge clk);
        bus.s_wvalid_i = 1'b0;
        #1 chk("wrap_mem1023", mem[1023], 32'h55);
        chk("wrap_mem0", mem[0], 32'h66);

        @(negedge clk);
        bus.s_raddr_i = 32'hffc;
        bus.s_rlen_i = 8'd3;
        bus.s_rvalid_i = 1'b1;
        repeat (3) @(negedge clk);
        #1 chk("abort_rready", bus.s_rready_o, 1);
        chk("abort_rdata", bus.s_rdata_o, 32'h55);
        @(negedge clk);
        rst = 1'b1;
        bus.s_rvalid_i = 1'b0;
        @(negedge clk);
        #1 chk("abort_rst_rready", bus.s_rready_o, 0);
        chk("abort_rst_rlast", bus.s_rlast_o, 0);
        chk("abort_rst_rdata", bus.s_rdata_o, 0);
        chk("abort_rst_ren", bus.mem_ren_o, 0);
        chk("abort_rst_raddr", bus.mem_raddr_o, 0);
        chk("abort_rst_wready", bus.s_wready_o, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1 chk("abort_rel_wready", bus.s_wready_o, 1);
        chk("abort_rel_rready", bus.s_rready_o, 0);
        rd_held(32'h0, 8'd1, "post");

        rd_held(32'h400, 8'hff, "long");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
